// File: rtl/gate_gen_if.sv
// Bundles the gate generator's control, timing and status signals.
// The master side drives triggers and settings; the slave side is the generator itself.
interface gate_gen_if #(
  parameter int DATA_W = 16
);
  logic              din;
  logic              enable;
  logic [DATA_W-1:0] delay;
  logic [DATA_W-1:0] width;
  logic [DATA_W-1:0] holdoff;
  logic              clr_lost;
  logic              dout;
  logic              busy;
  logic [DATA_W-1:0] lost;

  modport master (
    output din, enable, delay, width, holdoff, clr_lost,
    input  dout, busy, lost
  );

  modport slave (
    input  din, enable, delay, width, holdoff, clr_lost,
    output dout, busy, lost
  );
endinterface

// File: rtl/gate_gen.sv
// Retriggerable-free gate generator: on a rising edge of din, waits delay cycles,
// then emits a gate of max(width,1) cycles, then holdoff dead cycles.
module gate_gen #(
  parameter int DATA_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  gate_gen_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, DELAY, GATE, HOLD} state_t;

  localparam logic [DATA_W-1:0] ZERO = '0;
  localparam logic [DATA_W-1:0] ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic              din_d_q;
  logic              armed_q, armed_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] width_q, width_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] lost_q, lost_d;
  logic              dout_q, dout_d;
  logic              busy_q, busy_d;
  logic              trig;

  // armed_q blocks a din that was already high when reset released
  assign trig    = bus.din & ~din_d_q & armed_q;
  assign armed_d = armed_q | ~bus.din;

  // Counters hold (remaining - 1) so an all-ones setting counts exactly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    hold_d  = hold_q;
    lost_d  = lost_q;
    case (state_q)
      IDLE: begin
        if (trig && bus.enable) begin
          width_d = bus.width;
          hold_d  = bus.holdoff;
          if (bus.delay != ZERO) begin
            state_d = DELAY;
            cnt_d   = bus.delay - ONE;
          end else begin
            state_d = GATE;
            cnt_d   = (bus.width == ZERO) ? ZERO : bus.width - ONE;
          end
        end
      end
      DELAY: begin
        if (cnt_q == ZERO) begin
          state_d = GATE;
          cnt_d   = (width_q == ZERO) ? ZERO : width_q - ONE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      GATE: begin
        if (cnt_q == ZERO) begin
          if (hold_q != ZERO) begin
            state_d = HOLD;
            cnt_d   = hold_q - ONE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      HOLD: begin
        if (cnt_q == ZERO) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.clr_lost) begin
      lost_d = ZERO;
    end else if (trig && bus.enable && (state_q != IDLE) && (lost_q != {DATA_W{1'b1}})) begin
      lost_d = lost_q + ONE;
    end
  end

  assign dout_d = (state_d == GATE);
  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      din_d_q <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      width_q <= '0;
      hold_q  <= '0;
      lost_q  <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      din_d_q <= bus.din;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      width_q <= width_d;
      hold_q  <= hold_d;
      lost_q  <= lost_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.dout = dout_q;
  assign bus.busy = busy_q;
  assign bus.lost = lost_q;

endmodule

// File: tb/tb_gate_gen.sv
// Directed bench for gate_gen: a 16-bit instance for sequencing/reset cases
// and a 4-bit instance for counter saturation and all-ones settings.
module tb_gate_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  gate_gen_if #(.DATA_W(16)) b16 ();
  gate_gen_if #(.DATA_W(4))  b4 ();

  gate_gen #(.DATA_W(16)) u16 (.clk(clk), .rst(rst), .bus(b16));
  gate_gen #(.DATA_W(4))  u4  (.clk(clk), .rst(rst), .bus(b4));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    b16.din = 0; b16.enable = 1; b16.delay = 0; b16.width = 0; b16.holdoff = 0; b16.clr_lost = 0;
    b4.din = 0;  b4.enable = 1;  b4.delay = 0;  b4.width = 0;  b4.holdoff = 0;  b4.clr_lost = 0;
    rst = 1;
    #1;
    checks++;
    if (b16.dout !== 1'b0 || b16.busy !== 1'b0 || b16.lost !== 16'd0) begin
      errors++;
      $display("FAIL reset16 got dout=%b busy=%b lost=%0d exp 0/0/0", b16.dout, b16.busy, b16.lost);
    end
    checks++;
    if (b4.dout !== 1'b0 || b4.busy !== 1'b0 || b4.lost !== 4'd0) begin
      errors++;
      $display("FAIL reset4 got dout=%b busy=%b lost=%0d exp 0/0/0", b4.dout, b4.busy, b4.lost);
    end
    tick(); tick();
    rst = 0;
    tick(); tick();
    $display("test_reset done");
  endtask

  // Gates at 14-17 and 24-27; the second trigger lands in the first IDLE cycle.
  task automatic test_basic();
    logic ed, eb;
    b16.delay = 3; b16.width = 4; b16.holdoff = 2; b16.enable = 1;
    for (int c = 0; c <= 34; c++) begin
      b16.din = (c == 10 || c == 20);
      ed = (c >= 14 && c <= 17) || (c >= 24 && c <= 27);
      eb = (c >= 11 && c <= 19) || (c >= 21 && c <= 29);
      checks++;
      if (b16.dout !== ed || b16.busy !== eb) begin
        errors++;
        $display("FAIL basic c=%0d got dout=%b busy=%b exp dout=%b busy=%b", c, b16.dout, b16.busy, ed, eb);
      end
      tick();
    end
    b16.din = 0;
    checks++;
    if (b16.lost !== 16'd0) begin
      errors++;
      $display("FAIL basic_lost got=%0d exp=0", b16.lost);
    end
    $display("test_basic done");
  endtask

  task automatic test_zero();
    logic e;
    b16.delay = 0; b16.width = 0; b16.holdoff = 0;
    for (int c = 0; c <= 12; c++) begin
      b16.din = (c == 5 || c == 7);
      e = (c == 6 || c == 8);
      checks++;
      if (b16.dout !== e || b16.busy !== e) begin
        errors++;
        $display("FAIL zero c=%0d got dout=%b busy=%b exp %b/%b", c, b16.dout, b16.busy, e, e);
      end
      tick();
    end
    b16.din = 0;
    checks++;
    if (b16.lost !== 16'd0) begin
      errors++;
      $display("FAIL zero_lost got=%0d exp=0", b16.lost);
    end
    $display("test_zero done");
  endtask

  task automatic test_lost();
    logic ed, eb;
    b16.delay = 2; b16.width = 5; b16.holdoff = 3;
    for (int c = 0; c <= 14; c++) begin
      b16.din = (c == 0 || c == 4 || c == 8);
      ed = (c >= 3 && c <= 7);
      eb = (c >= 1 && c <= 10);
      checks++;
      if (b16.dout !== ed || b16.busy !== eb) begin
        errors++;
        $display("FAIL lost_seq c=%0d got dout=%b busy=%b exp %b/%b", c, b16.dout, b16.busy, ed, eb);
      end
      tick();
    end
    b16.din = 0;
    checks++;
    if (b16.lost !== 16'd2) begin
      errors++;
      $display("FAIL lost_count got=%0d exp=2", b16.lost);
    end
    b16.clr_lost = 1;
    tick();
    b16.clr_lost = 0;
    checks++;
    if (b16.lost !== 16'd0) begin
      errors++;
      $display("FAIL lost_clear got=%0d exp=0", b16.lost);
    end
    $display("test_lost done");
  endtask

  task automatic test_enable();
    logic ed, eb;
    b16.enable = 0; b16.delay = 1; b16.width = 1; b16.holdoff = 0;
    for (int c = 0; c <= 6; c++) begin
      b16.din = (c == 2);
      checks++;
      if (b16.dout !== 1'b0 || b16.busy !== 1'b0) begin
        errors++;
        $display("FAIL enable_off c=%0d got dout=%b busy=%b exp 0/0", c, b16.dout, b16.busy);
      end
      tick();
    end
    // Settings change and enable drop after acceptance must not disturb the run.
    b16.enable = 1; b16.delay = 3; b16.width = 2; b16.holdoff = 0;
    for (int c = 0; c <= 10; c++) begin
      b16.din = (c == 0 || c == 3);
      if (c == 1) begin
        b16.delay = 7; b16.width = 9; b16.holdoff = 5;
      end
      if (c == 2) b16.enable = 0;
      ed = (c >= 4 && c <= 5);
      eb = (c >= 1 && c <= 5);
      checks++;
      if (b16.dout !== ed || b16.busy !== eb) begin
        errors++;
        $display("FAIL enable_drop c=%0d got dout=%b busy=%b exp %b/%b", c, b16.dout, b16.busy, ed, eb);
      end
      tick();
    end
    b16.din = 0; b16.enable = 1;
    checks++;
    if (b16.lost !== 16'd0) begin
      errors++;
      $display("FAIL enable_lost got=%0d exp=0", b16.lost);
    end
    $display("test_enable done");
  endtask

  task automatic test_reset_mid();
    b16.delay = 0; b16.width = 10; b16.holdoff = 0; b16.enable = 1;
    for (int c = 0; c < 6; c++) begin
      b16.din = (c == 0);
      tick();
    end
    checks++;
    if (b16.dout !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre got dout=%b exp=1", b16.dout);
    end
    b16.din = 1;
    rst = 1;
    #1;
    checks++;
    if (b16.dout !== 1'b0 || b16.busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async got dout=%b busy=%b exp 0/0", b16.dout, b16.busy);
    end
    tick(); tick();
    rst = 0;
    for (int c = 0; c <= 5; c++) begin
      checks++;
      if (b16.dout !== 1'b0 || b16.busy !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_held c=%0d got dout=%b busy=%b exp 0/0", c, b16.dout, b16.busy);
      end
      tick();
    end
    b16.din = 0;
    tick();
    b16.din = 1;
    tick();
    b16.din = 0;
    checks++;
    if (b16.dout !== 1'b1 || b16.busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_new got dout=%b busy=%b exp 1/1", b16.dout, b16.busy);
    end
    repeat (12) tick();
    $display("test_reset_mid done");
  endtask

  // All-ones delay/width/holdoff on 4 bits plus 20 rejected triggers.
  task automatic test_saturate();
    logic ed, eb;
    int n;
    logic [3:0] el;
    b4.delay = 15; b4.width = 15; b4.holdoff = 15; b4.enable = 1;
    for (int c = 0; c <= 50; c++) begin
      b4.din = (c == 0) || (c >= 2 && c <= 40 && (c % 2 == 0));
      ed = (c >= 16 && c <= 30);
      eb = (c >= 1 && c <= 45);
      n = (c < 3) ? 0 : ((c - 1) / 2 > 20 ? 20 : (c - 1) / 2);
      el = (n > 15) ? 4'd15 : n[3:0];
      checks++;
      if (b4.dout !== ed || b4.busy !== eb || b4.lost !== el) begin
        errors++;
        $display("FAIL sat c=%0d got dout=%b busy=%b lost=%0d exp %b/%b/%0d",
                 c, b4.dout, b4.busy, b4.lost, ed, eb, el);
      end
      tick();
    end
    b4.width = 1; b4.holdoff = 0;
    for (int c = 0; c <= 8; c++) begin
      b4.din = (c == 0 || c == 2 || c == 4);
      b4.clr_lost = (c == 2);
      el = (c <= 2) ? 4'd15 : (c <= 4 ? 4'd0 : 4'd1);
      checks++;
      if (b4.lost !== el) begin
        errors++;
        $display("FAIL sat_clr c=%0d got lost=%0d exp %0d", c, b4.lost, el);
      end
      tick();
    end
    b4.din = 0; b4.clr_lost = 0;
    $display("test_saturate done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_lost();
    test_enable();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
